accum_out_collector: RTL
========================

Name: accum_out_collector

Overview:
- Consumer end of the mac_more accumulator output stream. It captures deskewed rows from accum_out_chained_fifo_out into an output FIFO and frames them as a tile of num_rows rows.
- It presents the rows downstream on a valid/ready interface toward the ofmap buffer.
- It back-pressures the array controller with stall so that no row is lost.

Parameters:
- OC0, 4, width of the mac array; number of 32-bit lanes per row.
- DEPTH, 8, output FIFO depth in rows; power of two, at least 4.
- STALL_SLACK, 2, free slots reserved for rows already in flight when stall asserts; must be less than DEPTH.
- ROW_CNT_W, 16, width of the row counter and of num_rows.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: synchronous active-low reset.
- en, input, 1: array enable; a row is accepted only when en=1.
- start, input, 1: one-cycle pulse that begins a tile; honoured only in IDLE.
- num_rows, input, ROW_CNT_W: rows in the tile; sampled on start.
- accum_out_valid, input, 1: the row on accum_out_chained is valid this cycle.
- accum_out_chained, input, 32*OC0: deskewed row; lane i is bits [32*(i+1)-1 : 32*i].
- stall, output, 1: tells the controller to deassert en.
- ofmap_valid, output, 1: ofmap_data holds a row.
- ofmap_ready, input, 1: downstream accepts the row.
- ofmap_data, output, 32*OC0: FIFO head row, lane order unchanged.
- ofmap_last, output, 1: the head row is the final row of the tile.
- busy, output, 1: state is not IDLE.
- done, output, 1: one-cycle pulse when the tile has fully drained.
- overflow, output, 1: sticky error flag.

Behaviour:
- Reset (rst_n=0 at a clock edge), from any state including mid-tile:
  - state goes to IDLE; FIFO pointers and count go to 0; row counter goes to 0.
  - Outputs after reset: stall=0, ofmap_valid=0, ofmap_data=0, ofmap_last=0, busy=0, done=0, overflow=0.
- States:
  - IDLE:
    - start with num_rows>0 latches num_rows and goes to COLLECT.
    - start with num_rows=0 pulses done the next cycle and stays in IDLE.
  - COLLECT:
    - Push when accum_out_valid && en. The push writes {last, row} with last = (row_cnt == num_rows-1), then increments row_cnt.
    - The push of the last row moves the state to DRAIN and clears row_cnt.
  - DRAIN:
    - No pushes.
    - Popping the entry with last=1 pulses done in the same cycle the pop occurs, registered, so done is visible the following cycle; state returns to IDLE.
- Stray data: accum_out_valid in IDLE or DRAIN is dropped, sets overflow, and never reaches the FIFO.
- start outside IDLE is ignored.
- FIFO:
  - Registered; a row pushed at edge t is visible on ofmap_valid/ofmap_data/ofmap_last after edge t.
  - ofmap_valid = (count != 0).
  - Pop on ofmap_valid && ofmap_ready; the head is held stable while ofmap_ready=0.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop: legal at any count, including full; count is unchanged.
- Push when full with no pop: the row is dropped, overflow is set, and row_cnt still advances so framing is preserved.
- Pop when empty: no effect.
- stall:
  - Combinational: stall = (count >= DEPTH - STALL_SLACK).
  - Deasserts the cycle count drops below the threshold.
- overflow clears only on reset.
- busy = (state != IDLE).
- Data width rules:
  - No arithmetic on data; 32-bit lanes pass through bit-exact.
  - row_cnt has ROW_CNT_W bits; num_rows up to 2^ROW_CNT_W - 1 is supported.

Optional Feature:
- Macro: ACCUM_OUT_RELU_EN.
- Defined: each 32-bit lane is treated as signed and clamped to 0 when negative. The clamp is applied before the FIFO write, adds no latency, and is applied per lane independently.
- Undefined: lanes are stored unchanged.

Test Plan:
- Basic tile (OC0=4, DEPTH=8, num_rows=3, ofmap_ready=1):
  - Stimulus: push rows 0x1..,0x2..,0x3.. on consecutive cycles.
  - Required: each row appears one cycle after its push; ofmap_last=1 only on row 3; done pulses once; busy falls to 0.
- Backpressure (ofmap_ready=0, num_rows=8):
  - Stimulus: push rows one per cycle.
  - Required: stall rises when count=6; the controller drops en and 6 rows are held. Raising ofmap_ready drains them in order; stall falls at count=5.
- Overflow:
  - Stimulus: ignore stall and push 9 rows with ofmap_ready=0.
  - Required: the 9th row is dropped; overflow=1 and stays 1; the FIFO holds rows 1-8 intact.
- Full with simultaneous push and pop:
  - Stimulus: at count=8, push with ofmap_ready=1.
  - Required: count stays 8, no overflow, and the new row appears in order.
- Stray data and edge cases:
  - accum_out_valid in IDLE sets overflow with no FIFO entry.
  - start with num_rows=0 produces done one cycle later and busy stays 0.
  - Reset asserted mid-COLLECT (rows 2/5 in) clears every output to its reset value; a new start then works normally.
- ACCUM_OUT_RELU_EN:
  - Stimulus: row lanes {-5, 7, 0x80000000, 0}.
  - Required: output {0, 7, 0, 0} when the macro is defined; input unchanged when it is undefined.

Source files
------------

// File: rtl/accum_out_collector_if.sv
// Stream bundle between the accumulator output path and the ofmap buffer.
// It carries the deskewed row input and the valid/ready row output.
// master: the collector side, which takes rows in and drives the ofmap stream.
// slave:  the surrounding logic, which feeds rows and consumes the ofmap stream.
interface accum_out_collector_if #(
    parameter int OC0 = 4
);
    logic                 accum_out_valid;
    logic [32*OC0-1:0]    accum_out_chained;
    logic                 ofmap_valid;
    logic                 ofmap_ready;
    logic [32*OC0-1:0]    ofmap_data;
    logic                 ofmap_last;

    modport master (
        input  accum_out_valid,
        input  accum_out_chained,
        input  ofmap_ready,
        output ofmap_valid,
        output ofmap_data,
        output ofmap_last
    );

    modport slave (
        output accum_out_valid,
        output accum_out_chained,
        output ofmap_ready,
        input  ofmap_valid,
        input  ofmap_data,
        input  ofmap_last
    );
endinterface

// File: rtl/accum_out_collector.sv
// accum_out_collector: consumer end of the mac_more accumulator output.
// Deskewed rows are captured into a registered output FIFO and framed as a
// tile of num_rows rows. The last row of the tile is tagged in the FIFO so
// that done can fire when it leaves. stall warns the array controller early
// enough that rows already in flight still fit.
// Optional build macro ACCUM_OUT_RELU_EN: clamps each signed 32-bit lane to
// zero when negative, on the way into the FIFO. Without it, lanes are stored
// bit-exact.
module accum_out_collector #(
    parameter int OC0         = 4,
    parameter int DEPTH       = 8,
    parameter int STALL_SLACK = 2,
    parameter int ROW_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  start,
    input  logic [ROW_CNT_W-1:0]  num_rows,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    accum_out_collector_if.master bus
);

    localparam int DW    = 32 * OC0;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(DEPTH - STALL_SLACK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Each FIFO entry is {last, row}.
    logic [DW:0]            mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic [ROW_CNT_W-1:0]   row_cnt;
    logic [ROW_CNT_W-1:0]   rows_q;
    logic                   done_q;
    logic                   overflow_q;

    logic                   push_req;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   fifo_valid;
    logic                   row_last;
    logic                   stray;
    logic                   done_set;
    logic                   overflow_set;
    logic [DW:0]            head;
    logic [DW-1:0]          row_in;

`ifdef ACCUM_OUT_RELU_EN
    // Clamp each lane independently to zero when its sign bit is set.
    always_comb begin
        row_in = bus.accum_out_chained;
        for (int i = 0; i < OC0; i++) begin
            if (bus.accum_out_chained[32*i+31]) begin
                row_in[32*i +: 32] = '0;
            end
        end
    end
`else
    assign row_in = bus.accum_out_chained;
`endif

    assign full       = (count == FULL_CNT);
    assign fifo_valid = (count != '0);
    assign pop        = fifo_valid && bus.ofmap_ready;
    assign head       = mem[rd_ptr];
    assign row_last   = (row_cnt == (rows_q - ROW_CNT_W'(1)));

    // A full FIFO still takes a row if the head leaves in the same cycle.
    assign push         = push_req && (!full || pop);
    assign overflow_set = stray || (push_req && full && !pop);

    assign bus.ofmap_valid = fifo_valid;
    assign bus.ofmap_data  = fifo_valid ? head[DW-1:0] : '0;
    assign bus.ofmap_last  = fifo_valid && head[DW];
    assign stall           = (count >= STALL_TH);
    assign busy            = (state != IDLE);
    assign done            = done_q;
    assign overflow        = overflow_q;

    // Tile state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, push request, stray detection and done request.
    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        stray      = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                stray = bus.accum_out_valid;
                if (start) begin
                    if (num_rows == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_next = COLLECT;
                    end
                end
            end
            COLLECT: begin
                push_req = bus.accum_out_valid && en;
                if (push_req && row_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                stray = bus.accum_out_valid;
                if (pop && head[DW]) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; entries are only ever read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {row_last, row_in};
        end
    end

    // Tile framing, done pulse and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt    <= '0;
            rows_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                rows_q <= num_rows;
            end
            if (push_req) begin
                row_cnt <= row_last ? '0 : row_cnt + ROW_CNT_W'(1);
            end
            done_q <= done_set;
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
